// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, one trial subtract per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] quo_q, rem_q, dsr_q, dvd_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;
  logic [WIDTH:0]   shift_d, trial_d;
  logic [WIDTH-1:0] rem_d, quo_d, mag_dvd_d, mag_dsr_d, q_fix_d, r_fix_d;
`ifdef DIVIDER_SIGNED_EN
  logic             neg_q_q, neg_r_q;
`endif
  always_comb begin
    shift_d = {rem_q, quo_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, dsr_q};
    rem_d   = trial_d[WIDTH] ? shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
`ifdef DIVIDER_SIGNED_EN
    mag_dvd_d = dividend[WIDTH-1] ? -dividend : dividend;
    mag_dsr_d = divisor[WIDTH-1] ? -divisor : divisor;
    q_fix_d   = neg_q_q ? -quo_q : quo_q;
    r_fix_d   = neg_r_q ? -rem_q : rem_q;
`else
    mag_dvd_d = dividend;
    mag_dsr_d = divisor;
    q_fix_d   = quo_q;
    r_fix_d   = rem_q;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      dvd_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          quo_q       <= mag_dvd_d;
          dsr_q       <= mag_dsr_d;
          dvd_q       <= dividend;
          rem_q       <= '0;
          cnt_q       <= '0;
          zero_q      <= divisor == '0;
          div_by_zero <= 1'b0;
          busy        <= divisor != '0;
          state_q     <= divisor == '0 ? DONE : RUN;
`ifdef DIVIDER_SIGNED_EN
          neg_q_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_q     <= dividend[WIDTH-1];
`endif
        end
        RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            busy    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          // The pulse and results appear together, one cycle after the last iteration
          quotient    <= zero_q ? '1 : q_fix_d;
          remainder   <= zero_q ? dvd_q : r_fix_d;
          div_by_zero <= zero_q;
          done        <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
